bus_cycle_ctrl: RTL and testbench

BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

---
 rtl/bus_cycle_ctrl.sv | 155 +++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_ctrl.sv
// Bus cycle controller for a multiplexed address/data bus: sequences the
// IDLE -> T1 -> T2 -> (TW)* -> T3 -> IDLE cycle with registered bus strobes.
module bus_cycle_ctrl #(
    parameter int DATASIZE = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                req_wr,
    input  logic                req_io,
    input  logic [15:0]         addr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                ready,
    input  logic [DATASIZE-1:0] ad_in,
    output logic [7:0]          a_hi,
    output logic [DATASIZE-1:0] ad_out,
    output logic                ad_oe,
    output logic                ale,
    output logic                rd_n,
    output logic                wr_n,
    output logic                io_m,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [DATASIZE-1:0] rdata
);

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        TW,
        T3
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    state_t              state_q;
    logic [7:0]          waitCnt_q;
    logic                toFlag_q;
    logic                wrLat_q;
    logic [DATASIZE-1:0] wdata_q;
    logic [7:0]          aHi_q;
    logic [DATASIZE-1:0] adOut_q;
    logic                adOe_q;
    logic                ale_q;
    logic                rdN_q;
    logic                wrN_q;
    logic                ioM_q;
    logic                busy_q;
    logic                done_q;
    logic                timeout_q;
    logic [DATASIZE-1:0] rdata_q;

    // Every output is computed for the state being entered, so each bus pin
    // comes straight from a flop and is valid for the whole T-state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            toFlag_q  <= 1'b0;
            wrLat_q   <= 1'b0;
            wdata_q   <= '0;
            aHi_q     <= '0;
            adOut_q   <= '0;
            adOe_q    <= 1'b0;
            ale_q     <= 1'b0;
            rdN_q     <= 1'b1;
            wrN_q     <= 1'b1;
            ioM_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ale_q  <= 1'b0;
                    adOe_q <= 1'b0;
                    rdN_q  <= 1'b1;
                    wrN_q  <= 1'b1;
                    busy_q <= 1'b0;
                    if (req) begin
                        state_q   <= T1;
                        wrLat_q   <= req_wr;
                        wdata_q   <= wdata;
                        aHi_q     <= addr[15:8];
                        adOut_q   <= DATASIZE'(addr[7:0]);
                        adOe_q    <= 1'b1;
                        ale_q     <= 1'b1;
                        ioM_q     <= req_io;
                        busy_q    <= 1'b1;
                        waitCnt_q <= '0;
                        toFlag_q  <= 1'b0;
                    end
                end
                T1: begin
                    state_q <= T2;
                    ale_q   <= 1'b0;
                    if (wrLat_q) begin
                        adOut_q <= wdata_q;
                        adOe_q  <= 1'b1;
                        wrN_q   <= 1'b0;
                    end else begin
                        adOe_q  <= 1'b0;
                        rdN_q   <= 1'b0;
                    end
                end
                T2, TW: begin
                    // Strobes stay asserted; only the state and wait count move.
                    if (ready) begin
                        state_q <= T3;
                    end else if (state_q == TW && waitCnt_q == WAIT_LIMIT) begin
                        state_q  <= T3;
                        toFlag_q <= 1'b1;
                    end else begin
                        state_q   <= TW;
                        waitCnt_q <= waitCnt_q + 8'd1;
                    end
                end
                T3: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    rdN_q     <= 1'b1;
                    wrN_q     <= 1'b1;
                    adOe_q    <= 1'b0;
                    done_q    <= 1'b1;
                    timeout_q <= toFlag_q;
                    if (!wrLat_q) begin
                        rdata_q <= ad_in;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign a_hi    = aHi_q;
    assign ad_out  = adOut_q;
    assign ad_oe   = adOe_q;
    assign ale     = ale_q;
    assign rd_n    = rdN_q;
    assign wr_n    = wrN_q;
    assign io_m    = ioM_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed self-checking bench for bus_cycle_ctrl: read, I/O write with waits,
// wait-limit timeout, back-to-back requests and mid-cycle reset.
module tb_bus_cycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        req_wr;
    logic        req_io;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ready;
    logic [7:0]  ad_in;
    logic [7:0]  a_hi;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic        ale;
    logic        rd_n;
    logic        wr_n;
    logic        io_m;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [7:0]  rdata;

    int          checkCount;
    int          failCount;
    int          cycles;
    int          rdLow;
    logic        doneSeen;
    logic [15:0] expAddr;
    logic [15:0] nextAddr;
    logic        expWr;
    logic        nextWr;
    logic [7:0]  expData;
    logic [7:0]  lastRead;

    bus_cycle_ctrl #(
        .DATASIZE(8),
        .WAIT_MAX(15)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .req_wr (req_wr),
        .req_io (req_io),
        .addr   (addr),
        .wdata  (wdata),
        .ready  (ready),
        .ad_in  (ad_in),
        .a_hi   (a_hi),
        .ad_out (ad_out),
        .ad_oe  (ad_oe),
        .ale    (ale),
        .rd_n   (rd_n),
        .wr_n   (wr_n),
        .io_m   (io_m),
        .busy   (busy),
        .done   (done),
        .timeout(timeout),
        .rdata  (rdata)
    );

    // 10 ns clock; rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic w, input logic io,
                                 input logic [15:0] a, input logic [7:0] d,
                                 input logic rdy);
        req    = r;
        req_wr = w;
        req_io = io;
        addr   = a;
        wdata  = d;
        ready  = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        checkCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkByte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checkCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkCount32(input string tag, input int obs, input int exp);
        checkCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Linear sequence of directed scenarios; each tick samples 1 ns after the edge.
    initial begin
        checkCount = 0;
        failCount  = 0;
        rst_n      = 1'b0;
        ad_in      = 8'h00;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);

        #12;
        $display("[TB] reset values");
        checkByte("rst_a_hi", a_hi, 8'h00);
        checkByte("rst_ad_out", ad_out, 8'h00);
        checkOutput("rst_ad_oe", ad_oe, 1'b0);
        checkOutput("rst_ale", ale, 1'b0);
        checkOutput("rst_rd_n", rd_n, 1'b1);
        checkOutput("rst_wr_n", wr_n, 1'b1);
        checkOutput("rst_io_m", io_m, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_timeout", timeout, 1'b0);
        checkByte("rst_rdata", rdata, 8'h00);
        #1 rst_n = 1'b1;
        tick();
        checkOutput("idle_busy", busy, 1'b0);

        $display("[TB] memory read 2050");
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h2050, 8'h00, 1'b1);
        tick();
        checkOutput("rd_T1_ale", ale, 1'b1);
        checkByte("rd_T1_a_hi", a_hi, 8'h20);
        checkByte("rd_T1_ad_out", ad_out, 8'h50);
        checkOutput("rd_T1_ad_oe", ad_oe, 1'b1);
        checkOutput("rd_T1_rd_n", rd_n, 1'b1);
        checkOutput("rd_T1_busy", busy, 1'b1);
        checkOutput("rd_T1_io_m", io_m, 1'b0);
        req = 1'b0;
        tick();
        checkOutput("rd_T2_ale", ale, 1'b0);
        checkOutput("rd_T2_rd_n", rd_n, 1'b0);
        checkOutput("rd_T2_wr_n", wr_n, 1'b1);
        checkOutput("rd_T2_ad_oe", ad_oe, 1'b0);
        tick();
        checkOutput("rd_T3_rd_n", rd_n, 1'b0);
        checkOutput("rd_T3_done", done, 1'b0);
        ad_in = 8'hA5;
        tick();
        checkOutput("rd_done", done, 1'b1);
        checkOutput("rd_timeout", timeout, 1'b0);
        checkByte("rd_rdata", rdata, 8'hA5);
        checkOutput("rd_idle_rd_n", rd_n, 1'b1);
        checkOutput("rd_idle_busy", busy, 1'b0);
        checkByte("rd_idle_a_hi_hold", a_hi, 8'h20);
        tick();
        checkOutput("rd_done_pulse_end", done, 1'b0);

        $display("[TB] I/O write 0081 with two wait states");
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0081, 8'h3C, 1'b0);
        ad_in = 8'h11;
        tick();
        checkOutput("wr_T1_io_m", io_m, 1'b1);
        checkByte("wr_T1_a_hi", a_hi, 8'h00);
        checkByte("wr_T1_ad_out", ad_out, 8'h81);
        checkOutput("wr_T1_wr_n", wr_n, 1'b1);
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("wr_strobe_wr_n", wr_n, 1'b0);
            checkOutput("wr_strobe_rd_n", rd_n, 1'b1);
            checkByte("wr_strobe_ad_out", ad_out, 8'h3C);
            checkOutput("wr_strobe_ad_oe", ad_oe, 1'b1);
            checkOutput("wr_strobe_done", done, 1'b0);
        end
        ready = 1'b1;
        tick();
        checkOutput("wr_T3_wr_n", wr_n, 1'b0);
        checkOutput("wr_T3_done", done, 1'b0);
        tick();
        checkOutput("wr_done", done, 1'b1);
        checkOutput("wr_timeout", timeout, 1'b0);
        checkByte("wr_rdata_unchanged", rdata, 8'hA5);
        checkOutput("wr_idle_wr_n", wr_n, 1'b1);
        checkOutput("wr_idle_io_m_hold", io_m, 1'b1);
        checkOutput("wr_idle_ad_oe", ad_oe, 1'b0);

        $display("[TB] read with ready held low");
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234, 8'h00, 1'b0);
        ad_in = 8'h5A;
        tick();
        cycles   = 1;
        rdLow    = 0;
        doneSeen = 1'b0;
        req      = 1'b0;
        for (int i = 0; i < 40 && !doneSeen; i++) begin
            tick();
            cycles++;
            if (rd_n == 1'b0) rdLow++;
            if (done == 1'b1) doneSeen = 1'b1;
        end
        checkOutput("to_done_seen", doneSeen, 1'b1);
        checkCount32("to_done_cycle", cycles, 19);
        checkCount32("to_rd_low_cycles", rdLow, 17);
        checkOutput("to_timeout", timeout, 1'b1);
        checkByte("to_rdata", rdata, 8'h5A);
        tick();
        checkOutput("to_timeout_clear", timeout, 1'b0);
        checkOutput("to_done_clear", done, 1'b0);

        $display("[TB] back-to-back alternating cycles");
        lastRead = 8'h5A;
        expAddr  = 16'hA011;
        expWr    = 1'b0;
        expData  = 8'hC0;
        applyStimulus(1'b1, expWr, 1'b0, expAddr, expData, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("b2b_T1_ale", ale, 1'b1);
            checkOutput("b2b_T1_busy", busy, 1'b1);
            checkByte("b2b_T1_a_hi", a_hi, expAddr[15:8]);
            checkByte("b2b_T1_ad_out", ad_out, expAddr[7:0]);
            applyStimulus(1'b1, ~expWr, 1'b1, 16'hFFFF, 8'hEE, 1'b1);
            tick();
            checkOutput("b2b_T2_ale", ale, 1'b0);
            checkOutput("b2b_T2_rd_n", rd_n, expWr);
            checkOutput("b2b_T2_wr_n", wr_n, ~expWr);
            checkOutput("b2b_T2_io_m", io_m, 1'b0);
            if (expWr) checkByte("b2b_T2_ad_out", ad_out, expData);
            tick();
            checkOutput("b2b_T3_strobes", rd_n | wr_n, 1'b1);
            checkByte("b2b_T3_a_hi", a_hi, expAddr[15:8]);
            ad_in = 8'h10 + 8'(k);
            if (!expWr) lastRead = ad_in;
            nextAddr = expAddr + 16'h0101;
            nextWr   = ~expWr;
            applyStimulus(1'b1, nextWr, 1'b0, nextAddr, expData + 8'd1, 1'b1);
            tick();
            checkOutput("b2b_done", done, 1'b1);
            checkOutput("b2b_done_busy", busy, 1'b0);
            checkByte("b2b_rdata", rdata, lastRead);
            expAddr = nextAddr;
            expWr   = nextWr;
            expData = expData + 8'd1;
        end
        req = 1'b0;
        tick();
        checkOutput("b2b_end_busy", busy, 1'b0);

        $display("[TB] reset during wait state of a write");
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h4000, 8'h77, 1'b0);
        tick();
        req = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("ar_TW_wr_n", wr_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ar_wr_n", wr_n, 1'b1);
        checkOutput("ar_ad_oe", ad_oe, 1'b0);
        checkOutput("ar_busy", busy, 1'b0);
        checkByte("ar_rdata", rdata, 8'h00);
        #2 rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("ar_no_done", done, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0102, 8'h00, 1'b1);
        ad_in = 8'h99;
        tick();
        checkOutput("ar_next_T1_ale", ale, 1'b1);
        req = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("ar_next_done", done, 1'b1);
        checkOutput("ar_next_timeout", timeout, 1'b0);
        checkByte("ar_next_rdata", rdata, 8'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
